// File: rtl/alu_result_fifo.sv
// alu_result_fifo: circular result buffer behind the ALU.
// Accepts every valid_in word without stalling. Words leave in order over a
// valid/ready handshake. It reports occupancy and free-slot credit, and sets a
// sticky overflow flag whenever a word has to be dropped.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   result_in        ALU result word (sampled when valid_in=1)
//   valid_in         ALU result valid; there is no backpressure
//   data_out         head-of-buffer word, 0 when empty
//   valid_out        buffer holds at least one word
//   ready_in         consumer takes data_out this cycle
//   count_out        occupied entries
//   credit_out       free entries (DEPTH - count_out)
//   overflow_out     sticky: a valid_in word was dropped
//   clr_overflow_in  clears overflow_out on the next edge; a new drop wins
module alu_result_fifo #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [WIDTH-1:0]      result_in,
   input  logic                  valid_in,
   output logic [WIDTH-1:0]      data_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [DEPTH_LOG2:0]   count_out,
   output logic [DEPTH_LOG2:0]   credit_out,
   output logic                  overflow_out,
   input  logic                  clr_overflow_in
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned PW    = DEPTH_LOG2;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic [CW-1:0]    count;
   logic             overflow;

   logic full;
   logic pop;
   logic push;
   logic drop;

   // A full buffer can still take a word when the head leaves on the same edge.
   assign full = (count == CW'(DEPTH));
   assign pop  = valid_out & ready_in;
   assign push = valid_in & (~full | pop);
   assign drop = valid_in & ~push;

   assign valid_out    = (count != '0);
   assign data_out     = valid_out ? mem[rp] : '0;
   assign count_out    = count;
   assign credit_out   = CW'(DEPTH) - count;
   assign overflow_out = overflow;

   // Storage is not reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= result_in;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wp <= wp + PW'(1);
         end
         if (pop) begin
            rp <= rp + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow_in) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo (WIDTH=32, DEPTH=4). Vector expectations
// describe the outputs just after the edge on which the inputs were sampled.
module tb_alu_result_fifo;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DL2   = 2;
   localparam int unsigned DEPTH = 4;

   logic             clk;
   logic             resetn;
   logic [WIDTH-1:0] result_in;
   logic             valid_in;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             ready_in;
   logic [DL2:0]     count_out;
   logic [DL2:0]     credit_out;
   logic             overflow_out;
   logic             clr_overflow_in;

   int checks = 0;
   int errors = 0;

   alu_result_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .result_in       (result_in),
      .valid_in        (valid_in),
      .data_out        (data_out),
      .valid_out       (valid_out),
      .ready_in        (ready_in),
      .count_out       (count_out),
      .credit_out      (credit_out),
      .overflow_out    (overflow_out),
      .clr_overflow_in (clr_overflow_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vin;
      logic [31:0] din;
      logic        rdy;
      logic        clr;
      logic        e_valid;
      logic [31:0] e_data;
      int          e_count;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic vin, input logic [31:0] din,
                               input logic rdy, input logic clr,
                               input logic ev, input logic [31:0] ed,
                               input int ec, input logic eo);
      vec_t v;
      v.vin = vin; v.din = din; v.rdy = rdy; v.clr = clr;
      v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_ovf = eo;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                            input int ec, input logic eo);
      check({tag, " valid_out"},    32'(valid_out),    32'(ev));
      check({tag, " data_out"},     data_out,          ed);
      check({tag, " count_out"},    32'(count_out),    32'(ec));
      check({tag, " credit_out"},   32'(credit_out),   32'(DEPTH) - 32'(ec));
      check({tag, " overflow_out"}, 32'(overflow_out), 32'(eo));
   endtask

   task automatic step(input logic vin, input logic [31:0] din, input logic rdy, input logic clr);
      @(negedge clk);
      valid_in = vin; result_in = din; ready_in = rdy; clr_overflow_in = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0; valid_in = 1'b0; result_in = '0; ready_in = 1'b0; clr_overflow_in = 1'b0;

      // fill, overflow, drain, empty-pop, clear
      add(1, 32'h11, 0, 0, 1, 32'h11, 1, 0);
      add(1, 32'h22, 0, 0, 1, 32'h11, 2, 0);
      add(1, 32'h33, 0, 0, 1, 32'h11, 3, 0);
      add(1, 32'h44, 0, 0, 1, 32'h11, 4, 0);
      add(1, 32'h55, 0, 0, 1, 32'h11, 4, 1);
      add(0, 32'h0,  0, 0, 1, 32'h11, 4, 1);
      add(0, 32'h0,  1, 0, 1, 32'h22, 3, 1);
      add(0, 32'h0,  1, 0, 1, 32'h33, 2, 1);
      add(0, 32'h0,  1, 0, 1, 32'h44, 1, 1);
      add(0, 32'h0,  1, 0, 0, 32'h0,  0, 1);
      add(0, 32'h0,  1, 0, 0, 32'h0,  0, 1);
      add(0, 32'h0,  0, 1, 0, 32'h0,  0, 0);
      // full with simultaneous push and pop
      add(1, 32'h11, 0, 0, 1, 32'h11, 1, 0);
      add(1, 32'h22, 0, 0, 1, 32'h11, 2, 0);
      add(1, 32'h33, 0, 0, 1, 32'h11, 3, 0);
      add(1, 32'h44, 0, 0, 1, 32'h11, 4, 0);
      add(1, 32'h66, 1, 0, 1, 32'h22, 4, 0);
      add(0, 32'h0,  1, 0, 1, 32'h33, 3, 0);
      add(0, 32'h0,  1, 0, 1, 32'h44, 2, 0);
      add(0, 32'h0,  1, 0, 1, 32'h66, 1, 0);
      add(0, 32'h0,  1, 0, 0, 32'h0,  0, 0);
      // drop coinciding with clear: set wins
      add(1, 32'hA1, 0, 0, 1, 32'hA1, 1, 0);
      add(1, 32'hA2, 0, 0, 1, 32'hA1, 2, 0);
      add(1, 32'hA3, 0, 0, 1, 32'hA1, 3, 0);
      add(1, 32'hA4, 0, 0, 1, 32'hA1, 4, 0);
      add(1, 32'hA5, 0, 1, 1, 32'hA1, 4, 1);
      add(0, 32'h0,  1, 1, 1, 32'hA2, 3, 0);
      add(0, 32'h0,  1, 0, 1, 32'hA3, 2, 0);
      add(0, 32'h0,  1, 0, 1, 32'hA4, 1, 0);
      add(0, 32'h0,  1, 0, 0, 32'h0,  0, 0);
      // streaming with ready held high; first push into empty is not popped
      for (int i = 0; i < 10; i++) begin
         add(1, 32'(i), 1, 0, 1, 32'(i), 1, 0);
      end
      add(0, 32'h0, 1, 0, 0, 32'h0, 0, 0);

      // reset then idle
      repeat (3) @(posedge clk);
      #1;
      check_all("in_reset", 0, 32'h0, 0, 0);
      @(negedge clk);
      resetn = 1'b1;
      step(0, 32'h0, 0, 0);
      check_all("idle", 0, 32'h0, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].vin, vecs[i].din, vecs[i].rdy, vecs[i].clr);
         check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                   vecs[i].e_count, vecs[i].e_ovf);
      end

      // reset mid-operation: 3 entries with overflow set
      step(1, 32'hB1, 0, 0);
      step(1, 32'hB2, 0, 0);
      step(1, 32'hB3, 0, 0);
      step(1, 32'hB4, 0, 0);
      step(1, 32'hB5, 0, 0);
      step(0, 32'h0,  1, 0);
      check_all("pre_reset", 1, 32'hB2, 3, 1);
      #2;
      resetn = 1'b0;
      #1;
      check_all("async_reset", 0, 32'h0, 0, 0);
      @(negedge clk);
      resetn = 1'b1;
      step(1, 32'h77, 0, 0);
      check_all("post_reset_push", 1, 32'h77, 1, 0);
      step(0, 32'h0, 1, 0);
      check_all("post_reset_drain", 0, 32'h0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
